// File: rtl/dpcm_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel DPCM encoder/decoder pair.
// Residual limits and the default predictor start value are derived here so both ends agree.
package dpcm_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_RES_W  = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // A channel tag is always at least one bit wide, even for a single-channel build.
    function automatic int chanWidth(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

    function automatic int resMax(input int resW);
        return (1 << (resW - 1)) - 1;
    endfunction

    function automatic int resMin(input int resW);
        return -(1 << (resW - 1));
    endfunction

    function automatic int predInitDefault(input int dataW);
        return 1 << (dataW - 1);
    endfunction

    localparam int RES_MAX_DEF   = resMax(DEF_RES_W);
    localparam int RES_MIN_DEF   = resMin(DEF_RES_W);
    localparam int PRED_INIT_DEF = predInitDefault(DEF_DATA_W);

endpackage

// File: rtl/dpcm_quant.sv
// Combinational DPCM quantiser: prediction and sample in, clamped residual and reconstruction out.
// The reconstruction matches what a decoder rebuilds from the residual alone.
module dpcm_quant
    import dpcm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RES_W  = 4,
    parameter int SHIFT  = 0
) (
    input  logic        [DATA_W-1:0] pred_i,
    input  logic        [DATA_W-1:0] data_i,
    output logic signed [RES_W-1:0]  res_o,
    output logic                     sat_o,
    output logic        [DATA_W-1:0] recon_o
);

    localparam int SUM_W = DATA_W + SHIFT + 2;
    localparam logic signed [DATA_W:0] Q_MAX = (DATA_W+1)'(resMax(RES_W));
    localparam logic signed [DATA_W:0] Q_MIN = (DATA_W+1)'(resMin(RES_W));
    localparam logic signed [SUM_W-1:0] RECON_MAX = $signed({{(SHIFT+2){1'b0}}, {DATA_W{1'b1}}});

    logic signed [DATA_W:0]  diff;
    logic signed [DATA_W:0]  qRaw;
    logic signed [DATA_W:0]  qClamped;
    logic signed [SUM_W-1:0] qScaled;
    logic signed [SUM_W-1:0] predExt;
    logic signed [SUM_W-1:0] reconSum;

    assign diff = $signed({1'b0, data_i}) - $signed({1'b0, pred_i});
    assign qRaw = diff >>> SHIFT;

    always_comb begin
        qClamped = qRaw;
        sat_o    = 1'b0;
        if (qRaw > Q_MAX) begin
            qClamped = Q_MAX;
            sat_o    = 1'b1;
        end else if (qRaw < Q_MIN) begin
            qClamped = Q_MIN;
            sat_o    = 1'b1;
        end
    end

    assign res_o = qClamped[RES_W-1:0];

    // Wide enough that the scaled residual plus prediction can never wrap before clamping.
    assign qScaled  = SUM_W'(qClamped) <<< SHIFT;
    assign predExt  = $signed({{(SHIFT+2){1'b0}}, pred_i});
    assign reconSum = predExt + qScaled;

    always_comb begin
        recon_o = reconSum[DATA_W-1:0];
        if (reconSum[SUM_W-1]) begin
            recon_o = '0;
        end else if (reconSum > RECON_MAX) begin
            recon_o = '1;
        end
    end

endmodule

// File: rtl/dpcm_enc_mc.sv
// Multi-channel closed-loop DPCM encoder: per-channel predictors, one output register stage,
// valid/ready on both sides with in_ready combinationally derived from the output stage.
module dpcm_enc_mc
    import dpcm_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int RES_W     = 4,
    parameter  int SHIFT     = 0,
    parameter  int CHANNELS  = 2,
    parameter  int PRED_INIT = predInitDefault(DATA_W),
    localparam int CH_W      = chanWidth(CHANNELS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [CH_W-1:0]         in_chan,
    input  logic                    in_restart,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [RES_W-1:0] out_res,
    output logic [CH_W-1:0]         out_chan,
    output logic                    out_sat
);

    localparam logic [DATA_W-1:0] PRED_INIT_V = DATA_W'(PRED_INIT);

    logic [DATA_W-1:0]       pred_q [CHANNELS];
    logic                    outValid_q, outValid_d;
    logic signed [RES_W-1:0] outRes_q,   outRes_d;
    logic [CH_W-1:0]         outChan_q,  outChan_d;
    logic                    outSat_q,   outSat_d;

    logic                    inAccept;
    logic                    chanInRange;
    logic [DATA_W-1:0]       predSel;
    logic signed [RES_W-1:0] qRes;
    logic                    qSat;
    logic [DATA_W-1:0]       recon;

    assign in_ready    = !outValid_q || out_ready;
    assign inAccept    = in_valid && in_ready;
    assign chanInRange = int'(in_chan) < CHANNELS;

    // Out-of-range channels and restarts both encode against the fixed start value.
    always_comb begin
        predSel = PRED_INIT_V;
        if (!in_restart && chanInRange) begin
            predSel = pred_q[in_chan];
        end
    end

    dpcm_quant #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W),
        .SHIFT  (SHIFT)
    ) u_quant (
        .pred_i  (predSel),
        .data_i  (in_data),
        .res_o   (qRes),
        .sat_o   (qSat),
        .recon_o (recon)
    );

    always_comb begin
        outValid_d = outValid_q;
        outRes_d   = outRes_q;
        outChan_d  = outChan_q;
        outSat_d   = outSat_q;
        if (inAccept) begin
            outValid_d = 1'b1;
            outRes_d   = qRes;
            outChan_d  = in_chan;
            outSat_d   = qSat;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outRes_q   <= '0;
            outChan_q  <= '0;
            outSat_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                pred_q[i] <= PRED_INIT_V;
            end
        end else begin
            outValid_q <= outValid_d;
            outRes_q   <= outRes_d;
            outChan_q  <= outChan_d;
            outSat_q   <= outSat_d;
            if (inAccept && chanInRange) begin
                pred_q[in_chan] <= recon;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_res   = outRes_q;
    assign out_chan  = outChan_q;
    assign out_sat   = outSat_q;

endmodule

// File: tb/tb_dpcm_enc_mc.sv
// Randomised bench for dpcm_enc_mc: a SHIFT=0/2-channel and a SHIFT=2/3-channel instance share
// stimulus and are checked against an arithmetic reference of the encoding rules.
module tb_dpcm_enc_mc;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_restart = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = '0;
    logic [1:0] inChanWide = '0;

    logic              inReadyA, outValidA, outSatA;
    logic signed [3:0] outResA;
    logic [0:0]        outChanA;
    logic              inReadyB, outValidB, outSatB;
    logic signed [3:0] outResB;
    logic [1:0]        outChanB;

    int checks = 0;
    int errors = 0;

    int predA [2];
    int predB [3];
    int expValid;
    int expResA, expChanA, expSatA;
    int expResB, expChanB, expSatB;

    always #5 clock = ~clock;

    dpcm_enc_mc #(
        .DATA_W (8), .RES_W (4), .SHIFT (0), .CHANNELS (2), .PRED_INIT (128)
    ) dutA (
        .clock (clock), .reset (reset),
        .in_valid (in_valid), .in_ready (inReadyA),
        .in_data (in_data), .in_chan (inChanWide[0:0]), .in_restart (in_restart),
        .out_valid (outValidA), .out_ready (out_ready),
        .out_res (outResA), .out_chan (outChanA), .out_sat (outSatA)
    );

    dpcm_enc_mc #(
        .DATA_W (8), .RES_W (4), .SHIFT (2), .CHANNELS (3), .PRED_INIT (128)
    ) dutB (
        .clock (clock), .reset (reset),
        .in_valid (in_valid), .in_ready (inReadyB),
        .in_data (in_data), .in_chan (inChanWide), .in_restart (in_restart),
        .out_valid (outValidB), .out_ready (out_ready),
        .out_res (outResB), .out_chan (outChanB), .out_sat (outSatB)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Encoding rule in plain integer arithmetic: floor-divide, clamp, rebuild, clamp.
    function automatic void encode(input int shift, input int p, input int data,
                                   output int q, output int sat, output int r);
        int d, q0;
        d  = data - p;
        q0 = (d >= 0) ? (d / (1 << shift)) : -((-d + (1 << shift) - 1) / (1 << shift));
        q  = (q0 > 7) ? 7 : ((q0 < -8) ? -8 : q0);
        sat = (q != q0) ? 1 : 0;
        r  = p + q * (1 << shift);
        r  = (r < 0) ? 0 : ((r > 255) ? 255 : r);
    endfunction

    task automatic modelReset();
        expValid = 0;
        expResA = 0; expChanA = 0; expSatA = 0;
        expResB = 0; expChanB = 0; expSatB = 0;
        foreach (predA[i]) predA[i] = 128;
        foreach (predB[i]) predB[i] = 128;
    endtask

    task automatic checkAll();
        checkOutput("out_valid_a", int'(outValidA), expValid);
        checkOutput("out_res_a",   int'(outResA),   expResA);
        checkOutput("out_chan_a",  int'(outChanA),  expChanA);
        checkOutput("out_sat_a",   int'(outSatA),   expSatA);
        checkOutput("out_valid_b", int'(outValidB), expValid);
        checkOutput("out_res_b",   int'(outResB),   expResB);
        checkOutput("out_chan_b",  int'(outChanB),  expChanB);
        checkOutput("out_sat_b",   int'(outSatB),   expSatB);
    endtask

    task automatic doReset(input bit valid);
        reset = 1'b1; in_valid = valid; out_ready = 1'b0;
        @(posedge clock); #1;
        modelReset();
        checkAll();
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic applyStimulus(input bit valid, input int data, input int chan,
                                 input bit restart, input bit ordy);
        int expReady, p, q, s, r, cA;
        in_valid = valid; in_data = data[7:0]; inChanWide = chan[1:0];
        in_restart = restart; out_ready = ordy;
        #1;
        expReady = (expValid == 0 || ordy) ? 1 : 0;
        checkOutput("in_ready_a", int'(inReadyA), expReady);
        checkOutput("in_ready_b", int'(inReadyB), expReady);
        @(posedge clock); #1;
        if (valid && expReady == 1) begin
            cA = chan % 2;
            p = restart ? 128 : predA[cA];
            encode(0, p, data, q, s, r);
            predA[cA] = r;
            expResA = q; expSatA = s; expChanA = cA;
            p = (restart || chan >= 3) ? 128 : predB[chan];
            encode(2, p, data, q, s, r);
            if (chan < 3) predB[chan] = r;
            expResB = q; expSatB = s; expChanB = chan;
            expValid = 1;
        end else if (ordy) begin
            expValid = 0;
        end
        checkAll();
        @(negedge clock);
    endtask

    initial begin
        modelReset();
        doReset(1'b0);

        applyStimulus(1, 130, 0, 0, 1);
        checkOutput("t1_res", int'(outResA), 2);

        applyStimulus(1, 200, 0, 0, 1);
        checkOutput("t2_res_hi", int'(outResA), 7);
        checkOutput("t2_sat_hi", int'(outSatA), 1);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t2_res_lo", int'(outResA), -8);

        applyStimulus(1, 120, 1, 0, 1);
        checkOutput("t3_res_ch1", int'(outResA), -8);
        checkOutput("t3_sat_ch1", int'(outSatA), 0);
        applyStimulus(1, 129, 0, 0, 1);
        checkOutput("t3_res_ch0", int'(outResA), 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 10, 1, 0, 0);
        end
        applyStimulus(1, 10, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(1, 128, 0, 1, 1);
        checkOutput("t5_restart_a", int'(outResA), 0);
        applyStimulus(1, 135, 0, 1, 1);
        checkOutput("t5_shift_res_b", int'(outResB), 1);
        applyStimulus(1, 132, 0, 0, 1);
        checkOutput("t5_shift_recon_b", int'(outResB), 0);

        applyStimulus(1, 200, 3, 0, 1);
        applyStimulus(1, 140, 3, 0, 1);

        applyStimulus(1, 50, 0, 0, 1);
        applyStimulus(1, 60, 0, 0, 0);
        doReset(1'b1);
        applyStimulus(1, 130, 0, 0, 1);
        checkOutput("t6_res", int'(outResA), 2);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
